// File: rtl/loop_seq_pkg.sv
// Shared types and helpers for the multi-channel loop sequencer.
// The channel state encoding and the saturating adder live here so top and channel agree.
package loop_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Saturating add on 32-bit operands; the caller truncates to its counter width.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage

// File: rtl/loop_if.sv
// Per-channel loop report bundle: the channel drives it (Ctrl), the top reads it (Report).
interface loop_if #(
  parameter int IDX_W = 4
);
  logic [IDX_W-1:0] index;
  logic             valid;
  logic             done;

  modport Ctrl   (output index, valid, done);
  modport Report (input  index, valid, done);
endinterface

// File: rtl/loop_seq_ch.sv
// One loop channel: walks index 0..limit-1, one value per clock, then strobes done.
// Handshake: start is a level sampled only in IDLE; abort cancels RUN; neither is queued.
module loop_seq_ch #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] limit,
  output logic             busy,
  output logic [1:0]       state_dbg,
  loop_if.Ctrl             lp
);
  import loop_seq_pkg::*;

  state_e           state;
  logic [IDX_W-1:0] lim_q;
  logic [IDX_W-1:0] index_q;
  logic             valid_q;
  logic             done_q;
  logic             busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lim_q   <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // abort beats start when both arrive together
          if (start && !abort) begin
            lim_q   <= limit;
            index_q <= '0;
            busy_q  <= 1'b1;
            if (limit != '0) begin
              state   <= RUN;
              valid_q <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (index_q == lim_q - IDX_W'(1)) begin
            state   <= DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            index_q <= index_q + IDX_W'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign lp.index  = index_q;
  assign lp.valid  = valid_q;
  assign lp.done   = done_q;
  assign busy      = busy_q;
  assign state_dbg = state;

endmodule

// File: rtl/loop_seq_multi.sv
// NUM_CH independent loop channels flattened onto vector ports, plus a shared
// saturating count of completed jobs.
module loop_seq_multi #(
  parameter int IDX_W  = 4,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       abort,
  input  logic [NUM_CH*IDX_W-1:0] limit,
  output logic [NUM_CH*IDX_W-1:0] index,
  output logic [NUM_CH-1:0]       index_valid,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       busy,
  output logic [CNT_W-1:0]        done_count,
  output logic [NUM_CH*2-1:0]     state_dbg
);
  import loop_seq_pkg::*;

  localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                  : ((32'd1 << CNT_W) - 32'd1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    loop_if #(.IDX_W(IDX_W)) ch_if ();

    loop_seq_ch #(.IDX_W(IDX_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .start     (start[c]),
      .abort     (abort[c]),
      .limit     (limit[c*IDX_W +: IDX_W]),
      .busy      (busy[c]),
      .state_dbg (state_dbg[c*2 +: 2]),
      .lp        (ch_if.Ctrl)
    );

    assign index[c*IDX_W +: IDX_W] = ch_if.index;
    assign index_valid[c]          = ch_if.valid;
    assign done[c]                 = ch_if.done;
  end

  // Simultaneous completions on several channels land in the same cycle.
  logic [31:0] done_pop;
  always_comb begin
    done_pop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      done_pop = done_pop + 32'(done[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_count <= '0;
    end else begin
      done_count <= CNT_W'(sat_add(32'(done_count), done_pop, CNT_MAX));
    end
  end

endmodule

// File: tb/tb_loop_seq_multi.sv
// Bench for loop_seq_multi: a vector table of jobs plus hand sequences for reset,
// restart-in-DONE, concurrency and counter saturation (second instance with CNT_W=2).
module tb_loop_seq_multi;
  localparam int IDX_W  = 4;
  localparam int NUM_CH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]       start, abort;
  logic [NUM_CH*IDX_W-1:0] limit;
  logic [NUM_CH*IDX_W-1:0] index, index_s;
  logic [NUM_CH-1:0]       index_valid, done, busy;
  logic [NUM_CH-1:0]       index_valid_s, done_s, busy_s;
  logic [7:0]              done_count;
  logic [1:0]              done_count_s;
  logic [NUM_CH*2-1:0]     state_dbg, state_dbg_s;

  loop_seq_multi #(.IDX_W(IDX_W), .NUM_CH(NUM_CH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .limit(limit),
    .index(index), .index_valid(index_valid), .done(done), .busy(busy),
    .done_count(done_count), .state_dbg(state_dbg)
  );

  loop_seq_multi #(.IDX_W(IDX_W), .NUM_CH(NUM_CH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .limit(limit),
    .index(index_s), .index_valid(index_valid_s), .done(done_s), .busy(busy_s),
    .done_count(done_count_s), .state_dbg(state_dbg_s)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [IDX_W-1:0] exp_q[NUM_CH][$];
  int done_pend[NUM_CH];
  int exp_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp8();
    return (exp_cnt > 255) ? 255 : exp_cnt;
  endfunction

  function automatic int exp2();
    return (exp_cnt > 3) ? 3 : exp_cnt;
  endfunction

  // Every valid beat pops the next expected index; every done must be expected.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (index_valid[c]) begin
          if (exp_q[c].size() == 0) begin
            check("unexpected_beat", index[c*IDX_W +: IDX_W], -1);
          end else begin
            check("index_stream", index[c*IDX_W +: IDX_W], exp_q[c].pop_front());
          end
        end
        if (done[c]) begin
          check("done_expected", (done_pend[c] > 0) ? 1 : 0, 1);
          if (done_pend[c] > 0) done_pend[c]--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int ch, input int n);
    for (int i = 0; i < n; i++) exp_q[ch].push_back(IDX_W'(i));
  endtask

  typedef struct {
    int ch;
    int lim;
    int abort_at;   // index at which to raise abort, -1 for none
    bit both;       // start and abort together in IDLE
    int beats;      // expected valid beats
    bit exp_done;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int cyc;
    step();
    push_beats(v.ch, v.beats);
    if (v.exp_done) done_pend[v.ch]++;
    start[v.ch] = 1'b1;
    abort[v.ch] = v.both;
    limit[v.ch*IDX_W +: IDX_W] = IDX_W'(v.lim);
    step();
    start[v.ch] = 1'b0;
    abort[v.ch] = 1'b0;
    if (v.both) begin
      repeat (3) begin
        check("start_abort_idle", busy[v.ch], 0);
        step();
      end
    end else if (v.abort_at >= 0) begin
      cyc = 0;
      while (index[v.ch*IDX_W +: IDX_W] != IDX_W'(v.abort_at) && cyc < 40) begin
        step();
        cyc++;
      end
      check("abort_reach", cyc, v.abort_at);
      abort[v.ch] = 1'b1;
      step();
      abort[v.ch] = 1'b0;
      check("abort_busy", busy[v.ch], 0);
      check("abort_valid", index_valid[v.ch], 0);
      check("abort_freeze", index[v.ch*IDX_W +: IDX_W], v.abort_at);
      repeat (3) step();
      check("abort_count", done_count, exp8());
    end else begin
      cyc = 0;
      while (!done[v.ch] && cyc < 40) begin
        step();
        cyc++;
      end
      check("done_latency", cyc, v.lim);
      exp_cnt++;
      step();
      check("count", done_count, exp8());
      check("count_sat", done_count_s, exp2());
      check("idle_after_done", busy[v.ch], 0);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int cyc;
    int prev;
    vecs[0] = '{0, 5, -1, 1'b0, 5, 1'b1};
    vecs[1] = '{0, 0, -1, 1'b0, 0, 1'b1};
    vecs[2] = '{1, 15, -1, 1'b0, 15, 1'b1};
    vecs[3] = '{1, 8, 3, 1'b0, 4, 1'b0};
    vecs[4] = '{0, 4, -1, 1'b1, 0, 1'b0};
    vecs[5] = '{1, 1, -1, 1'b0, 1, 1'b1};
    vecs[6] = '{0, 15, 6, 1'b0, 7, 1'b0};
    vecs[7] = '{1, 7, -1, 1'b0, 7, 1'b1};
    for (int c = 0; c < NUM_CH; c++) done_pend[c] = 0;

    rst = 1'b1; start = '0; abort = '0; limit = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state and quiet idle
    repeat (10) begin
      check("idle_outputs", {index, index_valid, done, busy, done_count, done_count_s}, 0);
      step();
    end

    // Asynchronous reset in the middle of a job
    push_beats(0, 9);
    start[0] = 1'b1; limit[0 +: IDX_W] = 4'd9;
    step();
    start[0] = 1'b0;
    cyc = 0;
    while (index[0 +: IDX_W] != 4'd4 && cyc < 40) begin
      step();
      cyc++;
    end
    check("rst_reach_idx4", cyc, 4);
    rst = 1'b1;
    #1;
    check("rst_async_busy", busy, 0);
    check("rst_async_valid", index_valid, 0);
    check("rst_async_index", index, 0);
    check("rst_async_done", done, 0);
    step();
    rst = 1'b0;
    exp_q[0].delete();
    exp_cnt = 0;
    repeat (3) step();
    check("rst_no_count", done_count, 0);

    // Basic run with a restart attempt while in DONE
    push_beats(0, 5);
    done_pend[0]++;
    start[0] = 1'b1; limit[0 +: IDX_W] = 4'd5;
    step();
    start[0] = 1'b0;
    cyc = 0;
    while (!done[0] && cyc < 40) begin
      step();
      cyc++;
    end
    check("basic_latency", cyc, 5);
    start[0] = 1'b1; limit[0 +: IDX_W] = 4'd3;
    step();
    start[0] = 1'b0;
    exp_cnt++;
    check("restart_ignored", busy[0], 0);
    check("basic_count", done_count, exp8());
    step();
    check("restart_still_idle", busy[0], 0);

    // Table-driven jobs
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Concurrent start, simultaneous completion
    step();
    push_beats(0, 3); push_beats(1, 3);
    done_pend[0]++; done_pend[1]++;
    start = 2'b11; limit = {4'd3, 4'd3};
    step();
    start = '0;
    prev = done_count;
    cyc = 0;
    while (!done[0] && cyc < 40) begin
      step();
      cyc++;
    end
    check("conc_latency", cyc, 3);
    check("conc_both_done", done, 2'b11);
    exp_cnt += 2;
    step();
    check("conc_count_plus2", done_count, prev + 2);
    check("conc_count_sat", done_count_s, exp2());

    // Staggered starts: independent index streams
    push_beats(0, 6); push_beats(1, 4);
    done_pend[0]++; done_pend[1]++;
    start[0] = 1'b1; limit[0 +: IDX_W] = 4'd6;
    step();
    start[0] = 1'b0;
    step();
    start[1] = 1'b1; limit[IDX_W +: IDX_W] = 4'd4;
    step();
    start[1] = 1'b0;
    cyc = 0;
    while (busy != '0 && cyc < 40) begin
      step();
      cyc++;
    end
    check("stagger_finish", (cyc < 40) ? 1 : 0, 1);
    exp_cnt += 2;
    step();
    check("stagger_count", done_count, exp8());

    // Saturation of the narrow counter: 1,2,3,3,3
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) run_vec('{0, 1, -1, 1'b0, 1, 1'b1});

    // Drain checks
    repeat (2) step();
    for (int c = 0; c < NUM_CH; c++) begin
      check("queue_drained", exp_q[c].size(), 0);
      check("done_drained", done_pend[c], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/loop_seq_multi.md
# loop_seq_multi

Parametrised, clocked multi-channel loop sequencer. It replaces single-shot combinational loop evaluation with NUM_CH independent channels. Each channel walks an index from 0 to limit-1, one value per clock, then raises a one-cycle completion strobe. A shared saturating counter tallies completions. It sits between control logic that launches iteration jobs and downstream logic that consumes per-iteration indices through the Report side of a parametrised loop interface.

## Interface
- IDX_W, 4: index and limit width; max iterations per job = 2^IDX_W - 1
- NUM_CH, 2: number of independent channels
- CNT_W, 8: width of the shared completion counter
- clk  input  1  clock, all state updated on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  NUM_CH  per-channel launch request, sampled only in IDLE
- abort  input  NUM_CH  per-channel cancel request
- limit  input  NUM_CH x IDX_W  per-channel iteration count, latched on accepted start
- index  output  NUM_CH x IDX_W  current iteration index
- index_valid  output  NUM_CH  index is a live iteration this cycle
- done  output  NUM_CH  one-cycle completion strobe
- busy  output  NUM_CH  channel not in IDLE
- done_count  output  CNT_W  total completions since reset, saturating

## Operation
- Per-channel FSM states:
  - IDLE: busy=0, no outputs active.
  - RUN: index_valid=1, index counts up by 1 per cycle.
  - DONE: done=1 for exactly one cycle.
- IDLE -> RUN: start=1, abort=0, latched limit != 0. Index loads 0.
- IDLE -> DONE: start=1, abort=0, limit == 0. The job completes with zero valid beats.
- RUN -> DONE: the cycle in which index == lim_q-1 and abort=0.
- RUN -> IDLE: abort=1. No done strobe, no count increment. The index freezes at its last value and index_valid drops.
- DONE -> IDLE: unconditionally.
- start is ignored in RUN and DONE. It is not queued.
- start and abort high together in IDLE: abort wins and the channel stays IDLE.
- abort in DONE is ignored. The completion still counts.
- Index arithmetic is IDX_W bits and never wraps, because lim_q ≤ 2^IDX_W - 1.
- done_count adds the popcount of done each cycle and saturates at 2^CNT_W - 1. Simultaneous completions on several channels add together in the same cycle.
- Channels are fully independent. No arbitration between them.
- Reset: all FSMs go to IDLE. index, lim_q, index_valid, done, busy and done_count are all 0.

## Timing
- start accepted at edge t:
  - RUN from t+1, index=0.
  - index=k at t+1+k.
  - Last index (limit-1) at t+limit.
  - done at t+limit+1.
  - IDLE at t+limit+2, which is the earliest next accepted start.
- busy is high from t+1 to t+limit+1 inclusive.
- limit==0: done at t+1, busy only at t+1.
- done_count reflects a done strobe one cycle after it (registered).
- abort sampled at edge a: index_valid and busy are low from a+1.
- rst asserted mid-job clears everything immediately, without waiting for a clock edge. No done strobe is emitted.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package loop_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE), 2 bits;
  - a saturating-add helper function.
- Interface loop_if, parametrised by IDX_W:
  - signals index, valid, done;
  - modports Ctrl (outputs) and Report (inputs).
- Sub-module loop_seq_ch is one channel: FSM, lim_q and index counter. It drives a loop_if Ctrl modport.
- The top level generates NUM_CH instances of loop_seq_ch, maps their Report modports to the flat output ports, and owns done_count.

## Test plan
- Reset then idle: all outputs 0 for 10 cycles with start=0. Assert rst mid-run on channel 0 (limit=9, at index 4) → busy, index_valid and index go to 0 immediately, with no done.
- Basic run, ch0 limit=5, start at t: index 0,1,2,3,4 valid at t+1..t+5, done at t+6, done_count=1 at t+7. Second start at t+6 (DONE) is ignored.
- Zero and maximum limit (IDX_W=4): limit=0 → done at t+1 with no valid beats. limit=15 → indices 0..14, done at t+16, index never wraps.
- Abort: ch1 limit=8, abort when index=3 → index_valid low next cycle, no done, done_count unchanged. start+abort together in IDLE → channel stays idle.
- Concurrency: ch0 and ch1 both limit=3, started the same cycle → simultaneous done, done_count increments by 2 in one cycle. Staggered starts keep independent index streams.
- Saturation, CNT_W=2: run 5 jobs → done_count sequence 1,2,3,3,3.
